// File: rtl/baud_gen_if.sv
// Control and strobe bundle between baud_gen and the UART TX/RX logic.
// Signal semantics: there is no valid/ready pair on this bundle. cfg_load is
// a single-cycle strobe that is always accepted on the clock edge that samples
// it (the generator never back-pressures); div_int/div_frac only need to be
// stable in that cycle. sync is a single-cycle phase-restart strobe. tick,
// bit_tick and mid_tick are single-cycle registered strobes; b_clk is a level.
interface baud_gen_if #(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4
);
  logic              en;
  logic              cfg_load;
  logic [DIV_W-1:0]  div_int;
  logic [FRAC_W-1:0] div_frac;
  logic              sync;
  logic              tick;
  logic              bit_tick;
  logic              mid_tick;
  logic              b_clk;

  // Controller side (UART core / testbench).
  modport master (
    output en, cfg_load, div_int, div_frac, sync,
    input  tick, bit_tick, mid_tick, b_clk
  );

  // Generator side.
  modport slave (
    input  en, cfg_load, div_int, div_frac, sync,
    output tick, bit_tick, mid_tick, b_clk
  );
endinterface

// File: rtl/baud_gen.sv
// Baud-rate / oversampling tick generator. A period counter with an
// integer-plus-fractional divisor produces the oversample tick; a sub-counter
// over OVERSAMPLE ticks derives the bit strobe, mid-bit strobe and a baud-rate
// square wave. sync restarts the bit phase (receiver start-bit alignment).
module baud_gen #(
  parameter int OVERSAMPLE   = 16,
  parameter int DIV_W        = 16,
  parameter int FRAC_W       = 4,
  parameter int DEFAULT_DIV  = 54,
  parameter int DEFAULT_FRAC = 4
) (
  input  logic       clk,
  input  logic       rst,
  baud_gen_if.slave  bus
);

  localparam int SUB_W = $clog2(OVERSAMPLE);
  // One extra bit so D + carry never overflows the period arithmetic.
  localparam int CNT_W = DIV_W + 1;

  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(OVERSAMPLE - 1);
  localparam logic [SUB_W-1:0] SUB_MID  = SUB_W'(OVERSAMPLE / 2 - 1);

  // Active divisor (shadow registers) and pending configuration.
  logic [DIV_W-1:0]  div_q,      div_d;
  logic [FRAC_W-1:0] frac_q,     frac_d;
  logic [DIV_W-1:0]  pend_div_q, pend_div_d;
  logic [FRAC_W-1:0] pend_frac_q, pend_frac_d;
  logic              pend_q,     pend_d;

  // Period counter, fractional accumulator and the carry that stretches the
  // current period by one clock.
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [FRAC_W-1:0] acc_q,   acc_d;
  logic              carry_q, carry_d;

  // Bit-phase sub-counter and registered outputs.
  logic [SUB_W-1:0]  sub_q,      sub_d;
  logic              tick_q,     tick_d;
  logic              bit_tick_q, bit_tick_d;
  logic              mid_tick_q, mid_tick_d;
  logic              b_clk_q,    b_clk_d;

  // Period arithmetic.
  logic [CNT_W-1:0]  div_ext;
  logic [CNT_W-1:0]  d_eff;
  logic [CNT_W-1:0]  last_cnt;
  logic              at_end;
  logic              wrap;
  logic              apply_cfg;
  logic [DIV_W-1:0]  src_div;
  logic [FRAC_W-1:0] src_frac;
  logic [FRAC_W:0]   acc_sum;

  // Divisors 0 and 1 are clamped to 2 so tick never becomes a constant level.
  assign div_ext  = {1'b0, div_q};
  assign d_eff    = (div_q < DIV_W'(2)) ? CNT_W'(2) : div_ext;
  assign last_cnt = d_eff + {{DIV_W{1'b0}}, carry_q} - CNT_W'(1);
  // >= rather than == so a divisor shrunk while paused cannot strand cnt.
  assign at_end   = (cnt_q >= last_cnt);
  assign wrap     = bus.en & ~bus.sync & at_end;

  // A same-cycle cfg_load wins over an older pending value, so the newest
  // configuration is the one applied at a boundary.
  assign src_div   = bus.cfg_load ? bus.div_int  : pend_div_q;
  assign src_frac  = bus.cfg_load ? bus.div_frac : pend_frac_q;
  // Apply only at a period boundary so no period is truncated; while paused
  // there is no period in flight, so apply on the next clock.
  assign apply_cfg = (bus.cfg_load | pend_q) & (~bus.en | wrap);

  // Fractional accumulate for the period that starts at this boundary uses
  // the divisor that will govern it (possibly the one being applied now).
  assign acc_sum = {1'b0, acc_q} + {1'b0, (apply_cfg ? src_frac : frac_q)};

  // Configuration path: shadow registers and pending capture.
  always_comb begin
    div_d       = div_q;
    frac_d      = frac_q;
    pend_div_d  = pend_div_q;
    pend_frac_d = pend_frac_q;
    pend_d      = pend_q;
    if (apply_cfg) begin
      div_d  = src_div;
      frac_d = src_frac;
      pend_d = 1'b0;
    end else if (bus.cfg_load) begin
      pend_div_d  = bus.div_int;
      pend_frac_d = bus.div_frac;
      pend_d      = 1'b1;
    end
  end

  // Counting path: sync first, then pause, then normal counting.
  always_comb begin
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    carry_d    = carry_q;
    sub_d      = sub_q;
    tick_d     = 1'b0;
    bit_tick_d = 1'b0;
    mid_tick_d = 1'b0;
    if (bus.sync) begin
      // Phase restart: the next period is exactly D with no fractional carry.
      cnt_d   = '0;
      acc_d   = '0;
      carry_d = 1'b0;
      sub_d   = '0;
    end else if (bus.en) begin
      if (wrap) begin
        cnt_d      = '0;
        acc_d      = acc_sum[FRAC_W-1:0];
        carry_d    = acc_sum[FRAC_W];
        sub_d      = sub_q + SUB_W'(1);
        tick_d     = 1'b1;
        bit_tick_d = (sub_q == SUB_LAST);
        mid_tick_d = (sub_q == SUB_MID);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    // OVERSAMPLE is a power of two, so sub >= OVERSAMPLE/2 is just the MSB.
    // sub only moves with en or sync, so b_clk freezes while paused.
    b_clk_d = sub_d[SUB_W-1];
  end

  // State registers; reset discards any pending configuration.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q       <= DIV_W'(DEFAULT_DIV);
      frac_q      <= FRAC_W'(DEFAULT_FRAC);
      pend_div_q  <= '0;
      pend_frac_q <= '0;
      pend_q      <= 1'b0;
      cnt_q       <= '0;
      acc_q       <= '0;
      carry_q     <= 1'b0;
      sub_q       <= '0;
      tick_q      <= 1'b0;
      bit_tick_q  <= 1'b0;
      mid_tick_q  <= 1'b0;
      b_clk_q     <= 1'b0;
    end else begin
      div_q       <= div_d;
      frac_q      <= frac_d;
      pend_div_q  <= pend_div_d;
      pend_frac_q <= pend_frac_d;
      pend_q      <= pend_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      carry_q     <= carry_d;
      sub_q       <= sub_d;
      tick_q      <= tick_d;
      bit_tick_q  <= bit_tick_d;
      mid_tick_q  <= mid_tick_d;
      b_clk_q     <= b_clk_d;
    end
  end

  assign bus.tick     = tick_q;
  assign bus.bit_tick = bit_tick_q;
  assign bus.mid_tick = mid_tick_q;
  assign bus.b_clk    = b_clk_q;

endmodule

// File: tb/tb_baud_gen.sv
// Directed testbench for baud_gen: reset state, default fractional cadence,
// bit/mid strobes and b_clk, reconfiguration, sync, pause, fractional sums and
// asynchronous reset.
module tb_baud_gen;

  localparam int OS     = 16;
  localparam int DIV_W  = 16;
  localparam int FRAC_W = 4;

  // Clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  baud_gen_if #(.DIV_W(DIV_W), .FRAC_W(FRAC_W)) bus ();

  baud_gen #(
    .OVERSAMPLE(OS), .DIV_W(DIV_W), .FRAC_W(FRAC_W),
    .DEFAULT_DIV(54), .DEFAULT_FRAC(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Scoreboard
  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drivers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns the number of clock edges until tick is seen (bounded).
  task automatic wait_tick(input string tag, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (bus.tick !== 1'b1 && n < 2000);
    check({tag, "_seen"}, {31'd0, bus.tick}, 32'd1);
  endtask

  task automatic load_cfg(input logic [DIV_W-1:0] d, input logic [FRAC_W-1:0] f);
    bus.cfg_load = 1'b1;
    bus.div_int  = d;
    bus.div_frac = f;
    step();
    bus.cfg_load = 1'b0;
  endtask

  initial begin
    int n, idx, mid_at, bit_at, sum, hi, viol, fv, k;
    logic frozen;

    rst          = 1'b0;
    bus.en       = 1'b0;
    bus.cfg_load = 1'b0;
    bus.div_int  = '0;
    bus.div_frac = '0;
    bus.sync     = 1'b0;
    repeat (3) step();

    check("rst_tick",     {31'd0, bus.tick},     32'd0);
    check("rst_bit_tick", {31'd0, bus.bit_tick}, 32'd0);
    check("rst_mid_tick", {31'd0, bus.mid_tick}, 32'd0);
    check("rst_b_clk",    {31'd0, bus.b_clk},    32'd0);

    // Defaults: first tick in cycle 55, then 54,54,54,55.
    @(negedge clk);
    rst    = 1'b1;
    bus.en = 1'b1;
    wait_tick("first", n);
    check("first_tick_cycle", n + 1, 32'd55);
    mid_at = 0;
    bit_at = 0;
    idx    = 1;
    exp_q  = '{32'd54, 32'd54, 32'd54, 32'd55};
    while (exp_q.size() > 0) begin
      wait_tick("dflt", n);
      idx++;
      if (bus.mid_tick && mid_at == 0) mid_at = idx;
      if (bus.bit_tick && bit_at == 0) bit_at = idx;
      check("dflt_interval", n, exp_q.pop_front());
    end
    while (idx < 16) begin
      wait_tick("dflt", n);
      idx++;
      if (bus.mid_tick && mid_at == 0) mid_at = idx;
      if (bus.bit_tick && bit_at == 0) bit_at = idx;
    end
    check("dflt_mid_index", mid_at, 32'd8);
    check("dflt_bit_index", bit_at, 32'd16);

    // One full bit: 868 clocks, b_clk high on 8 of the 16 ticks.
    sum = 0;
    hi  = 0;
    for (int i = 1; i <= 16; i++) begin
      wait_tick("bit", n);
      sum += n;
      if (bus.b_clk) hi++;
      if (i == 16) check("bit_tick_at_16", {31'd0, bus.bit_tick}, 32'd1);
    end
    check("bit_period", sum, 32'd868);
    check("b_clk_high_ticks", hi, 32'd8);

    // sync 20 cycles after a tick.
    repeat (20) step();
    bus.sync = 1'b1;
    step();
    bus.sync = 1'b0;
    check("sync_no_tick", {31'd0, bus.tick}, 32'd0);
    wait_tick("sync", n);
    check("sync_to_tick", n, 32'd54);
    mid_at = bus.mid_tick ? 1 : 0;
    bit_at = bus.bit_tick ? 1 : 0;
    idx    = 1;
    while (idx < 16) begin
      wait_tick("sync", n);
      idx++;
      if (bus.mid_tick && mid_at == 0) mid_at = idx;
      if (bus.bit_tick && bit_at == 0) bit_at = idx;
    end
    check("sync_mid_index", mid_at, 32'd8);
    check("sync_bit_index", bit_at, 32'd16);

    // Reconfigure mid-period: old period (17th after sync is 55) completes.
    repeat (5) step();
    load_cfg(16'd10, 4'd0);
    wait_tick("cfg10", n);
    check("cfg_old_period", n + 6, 32'd55);
    for (int i = 0; i < 3; i++) begin
      wait_tick("cfg10", n);
      check("cfg_new_interval", n, 32'd10);
    end

    // div_int=1 clamps to 2.
    repeat (2) step();
    load_cfg(16'd1, 4'd0);
    wait_tick("cfg1", n);
    check("cfg1_old_period", n + 3, 32'd10);
    for (int i = 0; i < 2; i++) begin
      wait_tick("cfg1", n);
      check("cfg1_interval", n, 32'd2);
    end

    // div 20 for the pause test.
    load_cfg(16'd20, 4'd0);
    wait_tick("cfg20", n);
    check("cfg20_old_period", n + 1, 32'd2);
    wait_tick("cfg20", n);
    check("cfg20_interval", n, 32'd20);

    // en low for 100 cycles, 7 cycles into a 20-cycle period.
    repeat (7) step();
    bus.en = 1'b0;
    frozen = bus.b_clk;
    viol   = 0;
    fv     = 0;
    repeat (100) begin
      step();
      if (bus.tick || bus.bit_tick || bus.mid_tick) viol++;
      if (bus.b_clk !== frozen) fv++;
    end
    check("en_low_strobes", viol, 32'd0);
    check("en_low_b_clk_frozen", fv, 32'd0);
    bus.en = 1'b1;
    wait_tick("resume", n);
    check("en_resume_remaining", n, 32'd13);

    // div 8, frac 15/16: 16 intervals sum to 143.
    load_cfg(16'd8, 4'd15);
    wait_tick("frac", n);
    check("frac_old_period", n + 1, 32'd20);
    sum = 0;
    hi  = 0;
    for (int i = 0; i < 16; i++) begin
      wait_tick("frac", n);
      sum += n;
      if (n != 8 && n != 9) hi++;
    end
    check("frac_sum", sum, 32'd143);
    check("frac_interval_range", hi, 32'd0);

    // Asynchronous reset between edges while tick and b_clk are high.
    k = 0;
    do begin
      step();
      k++;
    end while (!(bus.tick && bus.b_clk) && k < 400);
    check("async_precondition", {31'd0, bus.tick & bus.b_clk}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("async_tick",     {31'd0, bus.tick},     32'd0);
    check("async_bit_tick", {31'd0, bus.bit_tick}, 32'd0);
    check("async_mid_tick", {31'd0, bus.mid_tick}, 32'd0);
    check("async_b_clk",    {31'd0, bus.b_clk},    32'd0);
    repeat (2) step();
    @(negedge clk);
    rst = 1'b1;
    wait_tick("post_rst", n);
    check("post_rst_first_cycle", n + 1, 32'd55);
    wait_tick("post_rst", n);
    check("post_rst_interval", n, 32'd54);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/baud_gen.md
# baud_gen

Parametrised baud-rate and oversampling tick generator for the UART transmitter and receiver. It derives a one-cycle oversample `tick` from the system clock using a runtime-programmable integer-plus-fractional divisor. A sub-counter produces per-bit `bit_tick`, a mid-bit `mid_tick` sample strobe and a baud-rate square wave `b_clk`. A `sync` input lets the receiver realign the bit phase to a detected start-bit edge.

## Interface
- `OVERSAMPLE`, 16: ticks per bit; power of two, ≥4.
- `DIV_W`, 16: width of the integer divisor.
- `FRAC_W`, 4: width of the fractional divisor; resolution is 1/2^FRAC_W cycle.
- `DEFAULT_DIV`, 54: integer divisor loaded at reset (100 MHz, 115200 × 16).
- `DEFAULT_FRAC`, 4: fractional divisor loaded at reset (0.25).

Ports:
- `clk` in 1: system clock; all logic on the rising edge.
- `rst` in 1: one clock; reset is asynchronous and active-low.
- `en` in 1: count enable.
- `cfg_load` in 1: one-cycle strobe that captures `div_int` and `div_frac`.
- `div_int` in DIV_W: integer tick period, in clocks.
- `div_frac` in FRAC_W: fractional tick period, in units of 1/2^FRAC_W clock.
- `sync` in 1: phase restart.
- `tick` out 1: oversample strobe, one cycle wide.
- `bit_tick` out 1: strobe at the end of each bit period.
- `mid_tick` out 1: strobe at the middle of each bit period.
- `b_clk` out 1: square wave at the baud rate.

## Operation
- Shadow registers `div_q` and `frac_q` hold the active divisor. Reset values are DEFAULT_DIV and DEFAULT_FRAC.
- `cfg_load` captures the divisor inputs into a pending register and sets a pending flag.
  - The pending value is applied at the next tick boundary, so no period is truncated.
  - If `en`=0, the pending value is applied on the next clock.
  - A second `cfg_load` before the value is applied overwrites the pending value.
- Effective integer divisor D = max(`div_q`, 2). Values 0 and 1 are clamped to 2.
- Period counter `cnt` runs 0..P−1, where P = D + c.
  - c is the carry out of the fractional accumulator `acc` (FRAC_W bits) from the update at the start of that period.
  - At each period start, `acc` ← (`acc` + `frac_q`) mod 2^FRAC_W, and c = carry out of that add.
  - Example: `frac_q`=4, FRAC_W=4 gives periods 54, 54, 54, 55, repeating.
- `tick` is registered. It is high for exactly one cycle, in the cycle after `cnt` reaches P−1.
- Sub-counter `sub` (log2 OVERSAMPLE bits) increments on each tick and wraps from OVERSAMPLE−1 to 0.
  - `bit_tick` = `tick` AND `sub` was OVERSAMPLE−1 before the increment.
  - `mid_tick` = `tick` AND `sub` was OVERSAMPLE/2−1 before the increment.
  - Both are registered and coincide with `tick`.
- `b_clk` is registered: 1 while `sub` ≥ OVERSAMPLE/2, otherwise 0.
- `sync`:
  - Clears `cnt`, `sub` and `acc`.
  - Suppresses any tick that would be issued in the following cycle.
  - `sync` has priority over every other event.
  - The next `tick` follows exactly D cycles after the `sync` edge.
- `en`=0:
  - `cnt`, `sub`, `acc` and `b_clk` hold.
  - `tick`, `bit_tick` and `mid_tick` are forced to 0.
  - `sync` is still honoured.
- Simultaneous `cfg_load` and tick boundary: the new value is applied at that boundary and governs the next period.

## Timing
- Reset state: `tick`=0, `bit_tick`=0, `mid_tick`=0, `b_clk`=0, `cnt`=0, `sub`=0, `acc`=0, pending flag=0.
- After reset release with `en`=1, the first `tick` is high in cycle D+1, where D = DEFAULT_DIV.
- Reset asserted mid-operation returns everything to the reset state immediately and discards the pending configuration.
- `bit_tick` period = sum of OVERSAMPLE consecutive tick periods.
  - Default configuration: 16 × 54.25 = 868 clocks.
- `mid_tick` occurs OVERSAMPLE/2 ticks after the preceding `bit_tick`, or after a `sync`.
- The latency from a `cfg_load` to the new period length is at most one tick period plus one cycle.
- `en` rising resumes counting from the held `cnt` with no extra delay.

## Test plan
- Reset, then `en`=1 with defaults:
  - first `tick` at cycle 55;
  - the next four tick intervals are 54, 54, 54, 55;
  - `bit_tick` every 868 cycles;
  - `b_clk` high for 8 ticks and low for 8 ticks.
- `div_int`=10, `div_frac`=0, `cfg_load` mid-period:
  - the current period completes at its old length;
  - every later interval is exactly 10;
  - `div_int`=1 gives an interval of 2.
- `sync` pulsed 20 cycles after a `tick`:
  - no tick in the following cycle;
  - next `tick` at 54 cycles after the sync;
  - `mid_tick` on the 8th tick after the sync, `bit_tick` on the 16th.
- `en` low for 100 cycles mid-bit:
  - all strobes are 0 throughout;
  - `b_clk` is frozen;
  - after `en` rises, the remaining tick interval equals the interval remaining when `en` fell.
- `rst` asserted asynchronously between clock edges during an active bit: all outputs go to 0 immediately, without waiting for a clock edge.
- `div_frac`=15 (FRAC_W=4) with `div_int`=8: over 16 ticks the intervals sum to 8×16 + 15 = 143 cycles.
